// File: rtl/stream_seq_sink_if.sv
// Valid/ready stream bundle between an upstream source and a sink.
interface stream_seq_sink_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/stream_seq_sink.sv
// Stream sink: applies a programmable backpressure pattern and checks that
// accepted words follow start + k*increment (mod 2^WIDTH). Keeps counts and
// a snapshot of the first mismatching transfer.
module stream_seq_sink #(
  parameter int unsigned WIDTH     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter bit          RESYNC    = 1'b0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  stream_seq_sink_if.slave  in_if,
  input  logic [WIDTH-1:0]  i_start_value,
  input  logic [WIDTH-1:0]  i_increment,
  input  logic [1:0]        i_ready_mode,
  output logic [31:0]       o_count,
  output logic [15:0]       o_err_count,
  output logic              o_err,
  output logic [WIDTH-1:0]  o_bad_expected,
  output logic [WIDTH-1:0]  o_bad_received
);

  typedef enum logic [1:0] {
    READY_ALWAYS = 2'd0,
    READY_NEVER  = 2'd1,
    READY_ALT    = 2'd2,
    READY_LFSR   = 2'd3
  } ready_mode_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  ready_mode_e      mode;
  logic             ready_q, ready_d;
  logic             tog_q, tog_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] inc_q;
  logic [31:0]      count_q, count_d;
  logic [15:0]      err_count_q, err_count_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] bad_exp_q, bad_exp_d;
  logic [WIDTH-1:0] bad_rcv_q, bad_rcv_d;
  logic             xfer;
  logic             mism;

  assign mode = ready_mode_e'(i_ready_mode);

  // Backpressure pattern: toggle and LFSR free-run; mode only selects the source.
  always_comb begin
    tog_d  = ~tog_q;
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    unique case (mode)
      READY_ALWAYS: ready_d = 1'b1;
      READY_NEVER:  ready_d = 1'b0;
      READY_ALT:    ready_d = tog_q;
      READY_LFSR:   ready_d = lfsr_d[0];
      default:      ready_d = 1'b0;
    endcase
  end

  // Sequence checker: counters, sticky error, first-mismatch snapshot.
  always_comb begin
    xfer        = in_if.valid & ready_q;
    mism        = (in_if.data != exp_q);
    exp_d       = exp_q;
    count_d     = count_q;
    err_count_d = err_count_q;
    err_d       = err_q;
    bad_exp_d   = bad_exp_q;
    bad_rcv_d   = bad_rcv_q;
    if (xfer) begin
      if (count_q != '1) count_d = count_q + 32'd1;
      if (mism) begin
        if (err_count_q != '1) err_count_d = err_count_q + 16'd1;
        err_d = 1'b1;
        if (!err_q) begin
          bad_exp_d = exp_q;
          bad_rcv_d = in_if.data;
        end
      end
      exp_d = (RESYNC && mism) ? (in_if.data + inc_q) : (exp_q + inc_q);
    end
  end

  // State registers; reset continuously recaptures start value and increment.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ready_q     <= 1'b0;
      tog_q       <= 1'b1;
      lfsr_q      <= LFSR_SEED;
      exp_q       <= i_start_value;
      inc_q       <= i_increment;
      count_q     <= '0;
      err_count_q <= '0;
      err_q       <= 1'b0;
      bad_exp_q   <= '0;
      bad_rcv_q   <= '0;
    end else begin
      ready_q     <= ready_d;
      tog_q       <= tog_d;
      lfsr_q      <= lfsr_d;
      exp_q       <= exp_d;
      count_q     <= count_d;
      err_count_q <= err_count_d;
      err_q       <= err_d;
      bad_exp_q   <= bad_exp_d;
      bad_rcv_q   <= bad_rcv_d;
    end
  end

  assign in_if.ready    = ready_q;
  assign o_count        = count_q;
  assign o_err_count    = err_count_q;
  assign o_err          = err_q;
  assign o_bad_expected = bad_exp_q;
  assign o_bad_received = bad_rcv_q;

endmodule
